nios_cpu_nios2_cpu_oci_dct_packer: RTL and testbench
====================================================

Name: nios_cpu_nios2_cpu_oci_dct_packer

Overview:
Producer end of the OCI direct-control-transfer (DCT) trace path. It collects 2-bit DCT codes from the CPU trace tap and packs them into a 30-bit buffer holding up to 15 codes. It emits the buffer with a 4-bit code count (dct_buffer/dct_count) to the OCI trace consumer over a valid/ready handshake. It sits between the CPU trace tap and the OCI trace FIFO/test bench.

Parameters:
- CODE_W, 2: bits per DCT code.
- SLOTS, 15: codes per packet. Buffer width = CODE_W*SLOTS = 30. Count width is 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active high.
- trace_enable  in  1  when low, dct_valid is ignored.
- dct_valid  in  1  a DCT code is presented this cycle.
- dct_code  in  2  DCT code.
- flush  in  1  request to emit a partial packet.
- pkt_ready  in  1  consumer accepts the packet.
- pkt_valid  out  1  packet present on dct_buffer/dct_count.
- dct_buffer  out  30  packed codes. Oldest code is in the highest occupied slot; newest is in bits [1:0].
- dct_count  out  4  number of valid codes, 1..15.
- overflow  out  1  sticky flag: a code was dropped.
- drop_count  out  8  number of dropped codes, saturates at 255.

Behaviour:
- Reset values: all outputs 0. The accumulator, its count and flush_pending are also cleared. A reset asserted mid-packet discards both the accumulator and any pending output packet. No partial emit occurs.
- Storage:
  - Accumulator acc[29:0] with count acc_cnt (0..15).
  - Output register (dct_buffer, dct_count, pkt_valid).
- Code acceptance:
  - A code is accepted when trace_enable & dct_valid and the accumulator is not full, or is full but unloads this cycle.
  - Accept: acc <= {acc[27:0], dct_code}; acc_cnt += 1.
  - Unused high slots stay 0.
- out_free = !pkt_valid | pkt_ready.
- Unload condition, evaluated on the post-accept contents:
  - (acc_cnt_next == 15) OR ((flush | flush_pending) & acc_cnt_next != 0).
  - If the condition holds and out_free: the output register loads acc_next/acc_cnt_next and pkt_valid <= 1.
  - The accumulator clears in the same cycle.
  - Latency: the completing code at cycle N gives pkt_valid at N+1.
- Accumulator already full (15 codes) entering a cycle:
  - If out_free: it unloads to the output, and any incoming code becomes the sole entry (acc_cnt = 1).
  - If not out_free: the incoming code is dropped; overflow <= 1; drop_count increments, saturating at 255.
- Flush:
  - flush with acc_cnt_next == 0 does nothing and is not latched.
  - flush while !out_free sets flush_pending. Codes keep accumulating and are included in the eventual packet.
  - flush_pending clears on unload.
  - flush in the same cycle as a code: the code is included in the flushed packet.
- Output handshake:
  - pkt_valid, dct_buffer and dct_count hold stable until a cycle with pkt_valid & pkt_ready.
  - On that cycle, with no new load, pkt_valid <= 0 and dct_buffer/dct_count <= 0.
  - Back-to-back load on a ready cycle is allowed, giving one packet per cycle of throughput.
- trace_enable low: the accumulator holds, flush is still honoured, and the output handshake continues.
- overflow and drop_count clear only on reset.

Test Plan:
1. Full packet: reset, pkt_ready=1, 15 consecutive codes (i mod 4) for i=0..14 -> one cycle after the 15th code: pkt_valid=1 for one cycle, dct_buffer=0x06C6C6C6, dct_count=15.
2. Partial flush: codes 3,2,1, then flush -> pkt_valid next cycle, dct_buffer=0x00000039, dct_count=3. A second flush with an empty accumulator produces no packet.
3. Backpressure: pkt_ready=0, send 31 codes -> first packet (count 15) held stable; accumulator fills to 15; 31st code dropped: overflow=1, drop_count=1. Raise pkt_ready -> packets of count 15 and 15 delivered in consecutive cycles; no further drops.
4. Pending flush: pkt_ready=0 with a packet held; send code 2, flush, then code 1 -> after pkt_ready=1, second packet dct_buffer=0x9, dct_count=2.
5. Simultaneous: accumulator at 14, code 3 plus flush in the same cycle, out free -> one packet with dct_count=15 and LSBs=3; no extra empty packet.
6. Reset mid-operation: 7 codes accumulated and a packet pending, then reset for one cycle -> all outputs 0. A subsequent single code plus flush gives dct_count=1.

Source files
------------

// File: rtl/nios_cpu_nios2_cpu_oci_dct_packer.sv
// DCT trace packer: gathers 2-bit direct-control-transfer codes from the CPU
// trace tap into a 15-slot shift accumulator and hands complete or flushed
// packets to the OCI trace consumer over a valid/ready handshake.
module nios_cpu_nios2_cpu_oci_dct_packer #(
  parameter int CODE_W = 2,
  parameter int SLOTS  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trace_enable,
  input  logic                      dct_valid,
  input  logic [CODE_W-1:0]         dct_code,
  input  logic                      flush,
  input  logic                      pkt_ready,
  output logic                      pkt_valid,
  output logic [CODE_W*SLOTS-1:0]   dct_buffer,
  output logic [3:0]                dct_count,
  output logic                      overflow,
  output logic [7:0]                drop_count
);

  localparam int BUF_W = CODE_W * SLOTS;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             flush_pending;

  logic             out_free;
  logic             code_in;
  logic             acc_full;
  logic [BUF_W-1:0] acc_post;
  logic [CNT_W-1:0] cnt_post;
  logic             unload;
  logic [BUF_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             fp_next;
  logic             load;
  logic [BUF_W-1:0] load_buf;
  logic [CNT_W-1:0] load_cnt;
  logic             drop;

  // Decide accept / unload / drop for this cycle from the current state.
  always_comb begin
    out_free = !pkt_valid || pkt_ready;
    code_in  = trace_enable && dct_valid;
    acc_full = (acc_cnt == FULL);
    acc_post = code_in ? {acc[BUF_W-CODE_W-1:0], dct_code} : acc;
    cnt_post = acc_cnt + CNT_W'(code_in);
    unload   = (cnt_post == FULL) || ((flush || flush_pending) && (cnt_post != '0));
    acc_next = acc;
    cnt_next = acc_cnt;
    fp_next  = flush_pending;
    load     = 1'b0;
    load_buf = acc;
    load_cnt = acc_cnt;
    drop     = 1'b0;
    if (acc_full) begin
      // A full accumulator can only have been held back by a busy output.
      if (out_free) begin
        load     = 1'b1;
        load_buf = acc;
        load_cnt = acc_cnt;
        acc_next = code_in ? BUF_W'(dct_code) : '0;
        cnt_next = code_in ? CNT_W'(1) : '0;
        // A flush arriving with the new code applies to that code.
        fp_next  = flush && code_in;
      end else begin
        drop     = code_in;
        fp_next  = flush_pending || flush;
      end
    end else if (unload && out_free) begin
      load     = 1'b1;
      load_buf = acc_post;
      load_cnt = cnt_post;
      acc_next = '0;
      cnt_next = '0;
      fp_next  = 1'b0;
    end else begin
      acc_next = acc_post;
      cnt_next = cnt_post;
      if (flush && (cnt_post != '0)) fp_next = 1'b1;
    end
  end

  // Accumulator and deferred-flush state.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc           <= '0;
      acc_cnt       <= '0;
      flush_pending <= 1'b0;
    end else begin
      acc           <= acc_next;
      acc_cnt       <= cnt_next;
      flush_pending <= fp_next;
    end
  end

  // Output packet register: load on unload, clear once the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_valid  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (load) begin
      pkt_valid  <= 1'b1;
      dct_buffer <= load_buf;
      dct_count  <= load_cnt;
    end else if (pkt_valid && pkt_ready) begin
      pkt_valid  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end
  end

  // Sticky drop statistics; the counter saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_nios_cpu_nios2_cpu_oci_dct_packer.sv
// Testbench for the DCT trace packer: directed scenarios plus a randomized run,
// all compared against a queue-based packet model.
module tb_nios_cpu_nios2_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trace_enable = 1'b0;
  logic        dct_valid = 1'b0;
  logic [1:0]  dct_code = 2'd0;
  logic        flush = 1'b0;
  logic        pkt_ready = 1'b0;
  logic        pkt_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          acc_q[$];
  bit          m_fp;
  bit          m_valid;
  logic [29:0] m_buf;
  logic [3:0]  m_cnt;
  bit          m_ovf;
  int          m_drop;

  nios_cpu_nios2_cpu_oci_dct_packer dut (
    .clk(clk), .reset(reset), .trace_enable(trace_enable), .dct_valid(dct_valid),
    .dct_code(dct_code), .flush(flush), .pkt_ready(pkt_ready), .pkt_valid(pkt_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pack_q();
    logic [29:0] v = '0;
    foreach (acc_q[i]) v = (v << 2) | 30'(acc_q[i]);
    return v;
  endfunction

  // Advance one clock and evolve the model using the inputs present at the edge.
  task automatic cyc();
    bit free, cin, loaded;
    @(posedge clk);
    loaded = 0;
    if (reset) begin
      acc_q.delete(); m_fp = 0; m_valid = 0; m_buf = '0; m_cnt = '0; m_ovf = 0; m_drop = 0;
    end else begin
      free = !m_valid || pkt_ready;
      cin  = trace_enable && dct_valid;
      if (acc_q.size() == 15) begin
        if (free) begin
          m_buf = pack_q(); m_cnt = 4'd15; loaded = 1;
          acc_q.delete();
          if (cin) acc_q.push_back(int'(dct_code));
          m_fp = flush && cin;
        end else begin
          if (cin) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
          if (flush) m_fp = 1;
        end
      end else begin
        if (cin) acc_q.push_back(int'(dct_code));
        if ((acc_q.size() == 15 || ((flush || m_fp) && acc_q.size() != 0)) && free) begin
          m_buf = pack_q(); m_cnt = 4'(acc_q.size()); loaded = 1;
          acc_q.delete(); m_fp = 0;
        end else if (flush && acc_q.size() != 0) m_fp = 1;
      end
      if (loaded) m_valid = 1;
      else if (m_valid && pkt_ready) begin m_valid = 0; m_buf = '0; m_cnt = '0; end
    end
    #1;
  endtask

  task automatic idle_inputs();
    dct_valid = 0; flush = 0; trace_enable = 1;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs(); pkt_ready = 0;
    cyc();
    reset = 0;
  endtask

  task automatic send(input logic [1:0] c, input logic f);
    dct_valid = 1; dct_code = c; flush = f;
    cyc();
    dct_valid = 0; flush = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({pkt_valid, dct_buffer, dct_count, overflow, drop_count} !== 44'd0)
      $display("FAIL reset_outputs: got v=%0d buf=%h cnt=%0d ovf=%0d drop=%0d want all 0",
               pkt_valid, dct_buffer, dct_count, overflow, drop_count);
    else n_pass++;
  endtask

  task automatic test_full_packet();
    do_reset(); pkt_ready = 1;
    for (int i = 0; i < 15; i++) begin
      send(2'(i % 4), 0);
      if (i < 14) begin
        n_checks++;
        if (pkt_valid !== 1'b0) $display("FAIL full_early_valid: got %0d want 0 at code %0d", pkt_valid, i);
        else n_pass++;
      end
    end
    n_checks++;
    if (pkt_valid !== 1'b1 || dct_buffer !== 30'h06C6C6C6 || dct_count !== 4'd15)
      $display("FAIL full_packet: got v=%0d buf=%h cnt=%0d want v=1 buf=06c6c6c6 cnt=15",
               pkt_valid, dct_buffer, dct_count);
    else n_pass++;
    cyc();
    n_checks++;
    if (pkt_valid !== 1'b0 || dct_count !== 4'd0)
      $display("FAIL full_one_cycle: got v=%0d cnt=%0d want v=0 cnt=0", pkt_valid, dct_count);
    else n_pass++;
  endtask

  task automatic test_partial_flush();
    do_reset(); pkt_ready = 1;
    send(2'd3, 0); send(2'd2, 0); send(2'd1, 0);
    flush = 1; cyc(); flush = 0;
    n_checks++;
    if (pkt_valid !== 1'b1 || dct_buffer !== 30'h39 || dct_count !== 4'd3)
      $display("FAIL partial_flush: got v=%0d buf=%h cnt=%0d want v=1 buf=39 cnt=3",
               pkt_valid, dct_buffer, dct_count);
    else n_pass++;
    cyc();
    flush = 1; cyc(); flush = 0; cyc();
    n_checks++;
    if (pkt_valid !== 1'b0) $display("FAIL empty_flush: got v=%0d want 0", pkt_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset(); pkt_ready = 0;
    for (int i = 0; i < 31; i++) begin
      send(2'($urandom_range(0, 3)), 0);
      if (i == 14) begin
        n_checks++;
        if (pkt_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== m_buf)
          $display("FAIL bp_first: got v=%0d cnt=%0d buf=%h want v=1 cnt=15 buf=%h",
                   pkt_valid, dct_count, dct_buffer, m_buf);
        else n_pass++;
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1 || dct_buffer !== m_buf)
      $display("FAIL bp_drop: got ovf=%0d drop=%0d buf=%h want ovf=1 drop=1 buf=%h",
               overflow, drop_count, dct_buffer, m_buf);
    else n_pass++;
    pkt_ready = 1; cyc();
    n_checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer !== m_buf)
      $display("FAIL bp_second: got v=%0d cnt=%0d buf=%h want v=1 cnt=15 buf=%h",
               pkt_valid, dct_count, dct_buffer, m_buf);
    else n_pass++;
    cyc();
    n_checks++;
    if (pkt_valid !== 1'b0 || drop_count !== 8'd1)
      $display("FAIL bp_drain: got v=%0d drop=%0d want v=0 drop=1", pkt_valid, drop_count);
    else n_pass++;
  endtask

  task automatic test_pending_flush();
    do_reset(); pkt_ready = 0;
    send(2'd0, 1);
    send(2'd2, 0);
    flush = 1; cyc(); flush = 0;
    send(2'd1, 0);
    n_checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd1)
      $display("FAIL pend_held: got v=%0d cnt=%0d want v=1 cnt=1", pkt_valid, dct_count);
    else n_pass++;
    pkt_ready = 1; cyc();
    n_checks++;
    if (pkt_valid !== 1'b1 || dct_buffer !== 30'h9 || dct_count !== 4'd2)
      $display("FAIL pend_flush: got v=%0d buf=%h cnt=%0d want v=1 buf=9 cnt=2",
               pkt_valid, dct_buffer, dct_count);
    else n_pass++;
    cyc();
  endtask

  task automatic test_simultaneous();
    do_reset(); pkt_ready = 1;
    for (int i = 0; i < 14; i++) send(2'($urandom_range(0, 3)), 0);
    send(2'd3, 1);
    n_checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd15 || dct_buffer[1:0] !== 2'd3 || dct_buffer !== m_buf)
      $display("FAIL simul_pkt: got v=%0d cnt=%0d buf=%h want v=1 cnt=15 buf=%h",
               pkt_valid, dct_count, dct_buffer, m_buf);
    else n_pass++;
    cyc();
    n_checks++;
    if (pkt_valid !== 1'b0) $display("FAIL simul_extra: got v=%0d want 0", pkt_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(); pkt_ready = 0;
    send(2'd1, 1);
    for (int i = 0; i < 7; i++) send(2'($urandom_range(0, 3)), 0);
    reset = 1; cyc(); reset = 0;
    n_checks++;
    if ({pkt_valid, dct_buffer, dct_count, overflow, drop_count} !== 44'd0)
      $display("FAIL midreset_outputs: got v=%0d buf=%h cnt=%0d want all 0",
               pkt_valid, dct_buffer, dct_count);
    else n_pass++;
    pkt_ready = 1;
    send(2'd2, 1);
    n_checks++;
    if (pkt_valid !== 1'b1 || dct_count !== 4'd1 || dct_buffer !== 30'd2)
      $display("FAIL midreset_single: got v=%0d cnt=%0d buf=%h want v=1 cnt=1 buf=2",
               pkt_valid, dct_count, dct_buffer);
    else n_pass++;
    cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      trace_enable = ($urandom_range(0, 9) != 0);
      dct_valid    = ($urandom_range(0, 3) != 0);
      dct_code     = 2'($urandom_range(0, 3));
      flush        = ($urandom_range(0, 15) == 0);
      pkt_ready    = (i % 600 < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      cyc();
      n_checks++;
      if (pkt_valid !== m_valid || dct_buffer !== m_buf || dct_count !== m_cnt ||
          overflow !== m_ovf || drop_count !== 8'(m_drop))
        $display("FAIL random_cycle %0d: got v=%0d buf=%h cnt=%0d ovf=%0d drop=%0d want v=%0d buf=%h cnt=%0d ovf=%0d drop=%0d",
                 i, pkt_valid, dct_buffer, dct_count, overflow, drop_count,
                 m_valid, m_buf, m_cnt, m_ovf, m_drop);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_partial_flush();
    test_backpressure();
    test_pending_flush();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
